mprj_sel_ctrl: RTL and testbench
================================

Name: mprj_sel_ctrl

Overview:
Wishbone slave that sits directly downstream of the management SoC Wishbone port inside user_project_wrapper, upstream of the shared user-project slots. It holds the active-project select, sequences a timed per-project reset on every selection change, and gates each slot's enable. It also muxes the selected slot's interrupts into user_irq with edge capture and an event counter.

Parameters:
NPROJ, 8, number of user-project slots
SEL_W, 3, select width; NPROJ ≤ 2**SEL_W
BASE_ADR, 32'h3000_0000, register block base; match on wbs_adr_i[31:5]
RST_CYCLES, 16, clocks the selected slot's reset is held asserted (≥1)

Ports:
wb_clk_i  input  1  sole clock
wb_rst_i  input  1  asynchronous, active-high reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte lanes
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
proj_irq  input  3*NPROJ  per-slot irq[2:0], slot k at [3k+2:3k]
proj_sel  output  SEL_W  active slot index
proj_en  output  NPROJ  one-hot slot enable
proj_rst  output  NPROJ  per-slot active-high reset
user_irq  output  3  pending interrupts to management SoC

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, proj_sel=0, proj_en=0, proj_rst=all 1s, user_irq=0, all registers 0, FSM=IDLE.
- Bus: hit = cyc&stb&(adr[31:5]==BASE_ADR[31:5]). ack asserted the clock after a hit and held 1 cycle; no ack while ack=1 (every access takes 2 cycles). Misses never ack. Writes honour wbs_sel_i per byte. wbs_dat_o registered with ack; 0 on unmapped offsets.
- Registers (adr[4:2]): 0 SEL RW [SEL_W-1:0]; 1 CTRL: bit0 EN RW, bit1 SRST write-1 pulse (reads 0), bit2 LOCK (optional feature); 2 STATUS RO: bit0 BUSY, [15:8] proj_sel, [31:16] EVCNT; 3 IRQ: [2:0] pending, write-1-to-clear; 4 EVCLR write-any clears EVCNT.
- SEL writes with value ≥ NPROJ ignored. A SEL write with a new value, or SRST=1, starts reset sequence; SEL write with same value does nothing.
- FSM: IDLE -> ASSERT (load counter RST_CYCLES; proj_rst[all]=1, proj_en=0) -> count down to 1 -> RELEASE (1 cycle: proj_rst[sel]=0, others stay 1) -> IDLE. In IDLE proj_en = EN ? onehot(proj_sel) : 0; proj_rst = ~onehot(proj_sel) when EN, else all 1s. BUSY=1 in ASSERT/RELEASE.
- A SEL write or SRST during ASSERT/RELEASE updates proj_sel and restarts ASSERT with full count.
- Interrupts: selected slot's irq synchronised by one flop; rising edge sets pending[i]; only sampled in IDLE with EN=1; edge detector cleared on any reset sequence. Simultaneous set and W1C on same bit: set wins. user_irq = pending.
- EVCNT: 16-bit, +1 per cycle with ≥1 new rising edge, saturates at 0xFFFF; EVCLR and increment same cycle -> 0.
- wb_rst_i mid-sequence: everything returns to reset values immediately.

Optional Feature:
MPRJ_SEL_LOCK_EN: defined -> CTRL bit2 LOCK is set-only; once 1, SEL writes and SRST are ignored (still acked) until wb_rst_i; LOCK reads back. Undefined -> bit2 reads 0, writes ignored, no lock logic.

Test Plan:
- Reset release, read STATUS at 0x3000_0008 -> 0x0000_0000; proj_rst=0xFF, proj_en=0x00; ack exactly 1 cycle after stb.
- Write CTRL=1, SEL=5 -> BUSY=1, proj_rst=0xFF for 16 cycles, then proj_rst=0xDF, proj_en=0x20, STATUS=0x0000_0500.
- Write SEL=9 (NPROJ=8) -> ack, proj_sel unchanged; read offset 0x1C -> 0, ack; access at 0x3000_0020 -> no ack.
- Slot 5 pulses irq[1] twice -> IRQ reads 0x2, EVCNT=2; write IRQ=0x2 coinciding with a new edge -> stays 0x2.
- Mid-ASSERT (cycle 8) write SEL=2 -> counter restarts, proj_en=0x04 after 16 more cycles + 1 release cycle.
- With MPRJ_SEL_LOCK_EN: write CTRL=0x5, then SEL=3 -> proj_sel unchanged, no BUSY; assert wb_rst_i -> LOCK=0.

Source files
------------

// File: rtl/mprj_sel_ctrl.sv
// Wishbone slot selector: holds the active user project, sequences its timed reset and captures its irqs.
// Latency: each register hit acks one cycle later; reselect holds reset RST_CYCLES cycles plus one release cycle.
// Backpressure: none, every access takes two cycles; define MPRJ_SEL_LOCK_EN for the set-only CTRL.LOCK bit.
module mprj_sel_ctrl #(
    parameter int          NPROJ      = 8,
    parameter int          SEL_W      = 3,
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          RST_CYCLES = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [3*NPROJ-1:0] proj_irq,
    output logic [SEL_W-1:0]   proj_sel,
    output logic [NPROJ-1:0]   proj_en,
    output logic [NPROJ-1:0]   proj_rst,
    output logic [2:0]         user_irq
);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             en;
    logic [2:0]       pending;
    logic [15:0]      evcnt;
    logic [2:0]       irq_sync, irq_prev, rise, slot_irq, w1c;
    logic [NPROJ-1:0] sel_oh;
    logic             hit, wr, busy, locked, lock_rd;
    logic             sel_wr, ctrl_wr, evclr, start;
    logic [2:0]       off;
    logic [31:0]      wmask, sel_word, rdata;
    logic             unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign hit   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    assign wr    = hit & wbs_we_i;
    assign off   = wbs_adr_i[4:2];
    assign busy  = (state != S_IDLE);
    assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    // Unwritten lanes keep the current select so a partial write is range-checked as a whole word.
    assign sel_word = (wbs_dat_i & wmask) | (32'(proj_sel) & ~wmask);
    assign sel_wr   = wr & (off == 3'd0) & ~locked & (sel_word < 32'(NPROJ))
                    & (sel_word[SEL_W-1:0] != proj_sel);
    assign ctrl_wr  = wr & (off == 3'd1) & wbs_sel_i[0];
    assign evclr    = wr & (off == 3'd4);
    assign w1c      = (wr & (off == 3'd3) & wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
    assign start    = sel_wr | (ctrl_wr & wbs_dat_i[1] & ~locked);

`ifdef MPRJ_SEL_LOCK_EN
    logic lock_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            lock_q <= 1'b0;
        else if (ctrl_wr & wbs_dat_i[2])
            lock_q <= 1'b1;
    end
    assign locked  = lock_q;
    assign lock_rd = lock_q;
`else
    assign locked  = 1'b0;
    assign lock_rd = 1'b0;
`endif

    assign sel_oh = NPROJ'(1) << proj_sel;

    always_comb begin
        slot_irq = 3'b000;
        for (int k = 0; k < NPROJ; k++)
            if (proj_sel == SEL_W'(k))
                slot_irq = proj_irq[3*k +: 3];
    end

    assign rise     = irq_sync & ~irq_prev & {3{~busy & en}};
    assign user_irq = pending;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        proj_en   = '0;
        proj_rst  = '1;
        case (state)
            S_IDLE: begin
                proj_en  = en ? sel_oh : '0;
                proj_rst = en ? ~sel_oh : '1;
            end
            S_ASSERT: begin
                if (cnt <= CNT_W'(1))
                    state_nxt = S_RELEASE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            S_RELEASE: begin
                proj_rst  = ~sel_oh;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A new select or soft reset always restarts the full assert window.
        if (start) begin
            state_nxt = S_ASSERT;
            cnt_nxt   = CNT_W'(RST_CYCLES);
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (off)
            3'd0:    rdata = 32'(proj_sel);
            3'd1:    rdata = {29'd0, lock_rd, 1'b0, en};
            3'd2:    rdata = {evcnt, 8'(proj_sel), 7'd0, busy};
            3'd3:    rdata = {29'd0, pending};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            proj_sel  <= '0;
            en        <= 1'b0;
            irq_sync  <= 3'b000;
            irq_prev  <= 3'b000;
            pending   <= 3'b000;
            evcnt     <= 16'd0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= hit ? rdata : 32'd0;
            if (sel_wr)
                proj_sel <= sel_word[SEL_W-1:0];
            if (ctrl_wr)
                en <= wbs_dat_i[0];
            // Edge history is flushed while a reset sequence runs.
            irq_sync <= busy ? 3'b000 : slot_irq;
            irq_prev <= busy ? 3'b000 : irq_sync;
            pending  <= (pending & ~w1c) | rise;
            if (evclr)
                evcnt <= 16'd0;
            else if ((|rise) && (evcnt != 16'hFFFF))
                evcnt <= evcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mprj_sel_ctrl.sv
// Scoreboarded bench for mprj_sel_ctrl: directed scenarios plus randomized register/irq traffic.
module tb_mprj_sel_ctrl;
    localparam int          NPROJ      = 8;
    localparam int          SEL_W      = 3;
    localparam int          RST_CYCLES = 16;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
    logic [3:0]         be = 4'h0;
    logic [31:0]        adr = 32'd0, wdat = 32'd0;
    logic               ack;
    logic [31:0]        rdat;
    logic [3*NPROJ-1:0] irq_vec = '0;
    logic [SEL_W-1:0]   proj_sel;
    logic [NPROJ-1:0]   proj_en, proj_rst;
    logic [2:0]         user_irq;

    mprj_sel_ctrl #(.NPROJ(NPROJ), .SEL_W(SEL_W), .BASE_ADR(BASE), .RST_CYCLES(RST_CYCLES)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we),
        .wbs_sel_i(be), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .proj_irq(irq_vec), .proj_sel(proj_sel), .proj_en(proj_en), .proj_rst(proj_rst),
        .user_irq(user_irq)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0, failures = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cycle);
        end
    endfunction

    // Reference model: register contents plus the clock on which the latest reset sequence began.
    logic [2:0]  m_sel = 3'd0;
    logic        m_en = 1'b0, m_lock = 1'b0, m_started = 1'b0;
    logic [2:0]  m_pend = 3'd0, m_prev = 3'd0;
    logic [15:0] m_evcnt = 16'd0;
    int          m_seq_w = -1000;

    function automatic void model_reset();
        m_sel = 3'd0; m_en = 1'b0; m_lock = 1'b0; m_pend = 3'd0; m_prev = 3'd0;
        m_evcnt = 16'd0; m_seq_w = -1000;
    endfunction

    function automatic void start_seq(input int hit);
        m_seq_w   = hit;
        m_prev    = 3'd0;
        m_started = 1'b1;
    endfunction

    function automatic void settle();
        logic [2:0] lvl, rose;
        lvl = irq_vec[3*m_sel +: 3];
        if (m_en) begin
            rose = lvl & ~m_prev;
            if (rose != 3'd0) begin
                m_pend = m_pend | rose;
                if (m_evcnt != 16'hFFFF) m_evcnt = m_evcnt + 16'd1;
            end
        end
        m_prev = lvl;
    endfunction

    function automatic void model_write(input logic [2:0] off, input logic [31:0] d,
                                        input logic [3:0] b, input int hit);
        logic [31:0] word, cur;
        logic        srst;
        m_started = 1'b0;
        cur = 32'(m_sel);
        case (off)
            3'd0: begin
                for (int i = 0; i < 4; i++) word[8*i +: 8] = b[i] ? d[8*i +: 8] : cur[8*i +: 8];
                if (!m_lock && word < NPROJ && word[2:0] != m_sel) begin
                    m_sel = word[2:0];
                    start_seq(hit);
                end
            end
            3'd1: if (b[0]) begin
                srst = d[1] && !m_lock;
                m_en = d[0];
`ifdef MPRJ_SEL_LOCK_EN
                if (d[2]) m_lock = 1'b1;
`endif
                if (srst) start_seq(hit);
            end
            3'd3: if (b[0]) m_pend = m_pend & ~d[2:0];
            3'd4: m_evcnt = 16'd0;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off, input int hit);
        logic busy;
        busy = (hit - m_seq_w >= 1) && (hit - m_seq_w <= RST_CYCLES + 1);
        case (off)
            3'd0:    return 32'(m_sel);
            3'd1:    return {29'd0, m_lock, 1'b0, m_en};
            3'd2:    return {m_evcnt, 8'(m_sel), 7'd0, busy};
            3'd3:    return {29'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    typedef struct packed {
        logic        chk;
        logic [2:0]  off;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    logic ack_q = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (ack) begin
            check("ack_width", {31'd0, ack_q}, 32'd0);
            if (sb_q.size() == 0)
                check("unexpected_ack", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                if (e.chk) check($sformatf("rd_off%0d", e.off), rdat, e.exp);
            end
        end
        ack_q = ack;
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int   hit, waited;
        logic got, mapped;
        sb_t  e;
        @(negedge clk);
        hit    = cycle + 1;
        mapped = (a[31:5] == BASE[31:5]);
        if (mapped) begin
            e.off = a[4:2];
            e.chk = !w;
            e.exp = 32'd0;
            if (w) model_write(a[4:2], d, b, hit);
            else   e.exp = model_read(a[4:2], hit);
            sb_q.push_back(e);
        end
        cyc_i = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; be = b;
        waited = 0; got = 1'b0;
        while (!got && waited < 8) begin
            @(negedge clk);
            waited++;
            got = ack;
        end
        if (mapped) check("ack_latency", 32'(waited), 32'd1);
        else        check("miss_noack", {31'd0, got}, 32'd0);
        cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] oh, er, ee;
        int d;
        oh = 8'b1 << m_sel;
        d  = cycle - m_seq_w;
        if (d >= 0 && d < RST_CYCLES) begin er = 8'hFF; ee = 8'h00; end
        else if (d == RST_CYCLES)     begin er = ~oh;   ee = 8'h00; end
        else if (m_en)                begin er = ~oh;   ee = oh;    end
        else                          begin er = 8'hFF; ee = 8'h00; end
        check({tag, "_rst"}, 32'(proj_rst), 32'(er));
        check({tag, "_en"}, 32'(proj_en), 32'(ee));
        check({tag, "_sel"}, 32'(proj_sel), 32'(m_sel));
        check({tag, "_irq"}, 32'(user_irq), 32'(m_pend));
    endtask

    task automatic irq_step(input logic [3*NPROJ-1:0] v);
        @(negedge clk);
        irq_vec = v;
        repeat (4) @(negedge clk);
        settle();
    endtask

    task automatic wait_seq();
        repeat (RST_CYCLES + 6) @(negedge clk);
        settle();
    endtask

    logic [3:0] be_tab [4] = '{4'hF, 4'h1, 4'h2, 4'hE};

    initial begin
        logic [31:0] d;
        logic        started;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_dat", rdat, 32'd0);
        rst = 1'b0;

        bus(0, BASE + 32'h08, 0, 4'hF);
        bus(1, BASE + 32'h04, 32'h1, 4'hF);
        bus(1, BASE + 32'h00, 32'h5, 4'hF);
        for (int i = 0; i < 20; i++) begin
            check_outputs("seq5");
            @(negedge clk);
        end
        bus(0, BASE + 32'h08, 0, 4'hF);

        bus(1, BASE + 32'h00, 32'h9, 4'hF);
        bus(0, BASE + 32'h00, 0, 4'hF);
        bus(0, BASE + 32'h1C, 0, 4'hF);
        bus(0, BASE + 32'h20, 0, 4'hF);

        irq_step(24'h010000); irq_step(24'h0);
        irq_step(24'h010000); irq_step(24'h0);
        bus(0, BASE + 32'h0C, 0, 4'hF);
        bus(0, BASE + 32'h08, 0, 4'hF);
        @(negedge clk);
        irq_vec[16] = 1'b1;
        bus(1, BASE + 32'h0C, 32'h2, 4'hF);
        settle();
        bus(0, BASE + 32'h0C, 0, 4'hF);
        check_outputs("setwins");

        irq_step(24'h0);
        @(negedge clk);
        irq_vec[16] = 1'b1;
        bus(1, BASE + 32'h10, 32'h0, 4'hF);
        settle();
        m_evcnt = 16'd0;    // a clear in the same cycle as an increment leaves zero
        bus(0, BASE + 32'h08, 0, 4'hF);
        irq_step(24'h0);

        bus(1, BASE + 32'h00, 32'h1, 4'hF);
        repeat (6) @(negedge clk);
        bus(1, BASE + 32'h00, 32'h2, 4'hF);
        for (int i = 0; i < 20; i++) begin
            check_outputs("restart");
            @(negedge clk);
        end
        settle();

        for (int n = 0; n < 150; n++) begin
            started = 1'b0;
            case ($urandom_range(0, 6))
                0: begin
                    d = 32'($urandom_range(0, 11));
                    if ($urandom_range(0, 3) == 0) d = d | 32'h200;
                    bus(1, BASE, d, be_tab[$urandom_range(0, 3)]);
                    started = m_started;
                    if ($urandom_range(0, 1) == 1) bus(0, BASE + 32'h08, 0, 4'hF);
                end
                1: begin
                    d = {29'd0, 3'($urandom_range(0, 7))};
                    d[0] = ($urandom_range(0, 3) != 0);
                    bus(1, BASE + 32'h04, d, ($urandom_range(0, 3) == 0) ? 4'h2 : 4'hF);
                    started = m_started;
                end
                2: bus(0, BASE + {27'd0, 3'($urandom_range(0, 7)), 2'b00}, 0, 4'hF);
                3: irq_step(24'($urandom));
                4: bus(1, BASE + 32'h0C, 32'($urandom_range(0, 7)), 4'hF);
                5: bus(1, BASE + 32'h10, 32'($urandom), 4'hF);
                default: bus(0, ($urandom_range(0, 1) == 1) ? BASE + 32'h20 + 32'($urandom_range(0, 7) * 4)
                                                             : 32'h2000_0008, 0, 4'hF);
            endcase
            if (started) wait_seq();
            check_outputs("rnd");
        end

        irq_step(24'h0);
        bus(1, BASE + 32'h04, 32'h3, 4'hF);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rstmid");
        check("rstmid_ack", {31'd0, ack}, 32'd0);
        check("rstmid_dat", rdat, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus(0, BASE + 32'h08, 0, 4'hF);
        bus(0, BASE + 32'h04, 0, 4'hF);

`ifdef MPRJ_SEL_LOCK_EN
        bus(1, BASE + 32'h04, 32'h5, 4'hF);
        bus(1, BASE + 32'h00, 32'h3, 4'hF);
        bus(0, BASE + 32'h00, 0, 4'hF);
        bus(0, BASE + 32'h08, 0, 4'hF);
        bus(0, BASE + 32'h04, 0, 4'hF);
        check_outputs("lock");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus(0, BASE + 32'h04, 0, 4'hF);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
